// File: rtl/uart_hex_rx_if.sv
// Serial input and parsed-output signals of the hex line receiver.
// The receiver takes the master view; whoever drives the line and consumes words takes the slave view.
interface uart_hex_rx_if;
  logic        uart_rx;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        frame_err;
  logic [31:0] word_data;
  logic        word_valid;

  modport master (
    input  uart_rx,
    output rx_data, rx_strobe, frame_err, word_data, word_valid
  );

  modport slave (
    output uart_rx,
    input  rx_data, rx_strobe, frame_err, word_data, word_valid
  );
endinterface

// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver feeding an ASCII hex line parser; each CR/LF-terminated
// line of 1..8 hex digits becomes a 32-bit word with a one-cycle valid strobe.
module uart_hex_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 500000
) (
  input  logic          clk,
  input  logic          reset,
  uart_hex_rx_if.master bus
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]    sync_reg;
  logic          rx_s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          armed_reg, armed_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_strobe_reg, rx_strobe_next;
  logic          frame_err_reg, frame_err_next;

  logic [31:0]   acc_reg;
  logic [3:0]    cnt_reg;
  logic          bad_reg;
  logic [31:0]   word_data_reg;
  logic          word_valid_reg;
  logic          is_hex;
  logic          is_term;
  logic [3:0]    nibble;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.uart_rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cyc_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      armed_reg     <= 1'b0;
      rx_data_reg   <= '0;
      rx_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      armed_reg     <= armed_next;
      rx_data_reg   <= rx_data_next;
      rx_strobe_reg <= rx_strobe_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // armed_reg blocks a held-low line (framing error, reset mid-byte) from being taken as a new start.
  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg + CW'(1);
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    armed_next     = armed_reg;
    rx_data_next   = rx_data_reg;
    rx_strobe_next = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cyc_next = '0;
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = START;
          bit_next   = '0;
        end
      end
      START: begin
        if (cyc_reg == HALF_LAST) begin
          cyc_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_reg == BIT_LAST) begin
          cyc_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cyc_reg == BIT_LAST) begin
          cyc_next   = '0;
          state_next = IDLE;
          armed_next = 1'b0;
          if (rx_s) begin
            rx_data_next   = shift_reg;
            rx_strobe_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Letters map to 10..15 by adding 9 to the low nibble of 'A'..'F' / 'a'..'f'.
  always_comb begin
    is_hex  = 1'b0;
    is_term = (rx_data_reg == 8'h0D) || (rx_data_reg == 8'h0A);
    nibble  = '0;
    if (rx_data_reg >= 8'h30 && rx_data_reg <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data_reg[3:0];
    end else if ((rx_data_reg >= 8'h41 && rx_data_reg <= 8'h46) ||
                 (rx_data_reg >= 8'h61 && rx_data_reg <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_data_reg[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      bad_reg        <= 1'b0;
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (frame_err_reg) begin
        bad_reg <= 1'b1;
      end else if (rx_strobe_reg) begin
        if (is_hex) begin
          if (cnt_reg == 4'd8) begin
            bad_reg <= 1'b1;
          end else begin
            acc_reg <= {acc_reg[27:0], nibble};
            cnt_reg <= cnt_reg + 4'd1;
          end
        end else if (is_term) begin
          if (!bad_reg && cnt_reg != 4'd0) begin
            word_data_reg  <= acc_reg;
            word_valid_reg <= 1'b1;
          end
          acc_reg <= '0;
          cnt_reg <= '0;
          bad_reg <= 1'b0;
        end else begin
          bad_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_strobe  = rx_strobe_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.word_data  = word_data_reg;
  assign bus.word_valid = word_valid_reg;
endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: table of serial lines with expected words, a byte/word
// scoreboard fed by the driver, and hand-written glitch and mid-byte reset sequences.
module tb_uart_hex_rx;
  localparam int NVEC = 11;

  logic clk = 1'b0;
  logic reset;

  uart_hex_rx_if bus();

  uart_hex_rx #(.CLK_FREQ(25000000), .BAUD(500000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       text;
    bit          bad_first;
    int          bitc;
    int          exp_words;
    logic [31:0] exp_word;
    int          exp_strobes;
    int          exp_ferrs;
  } vec_t;

  vec_t        vecs [NVEC];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  int          strobes, ferrs, words, word_cyc, last_fall_cyc;
  logic [7:0]  byte_q [$];
  logic [31:0] word_q [$];
  logic        prev_strobe = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_for(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int bitc);
    last_fall_cyc = cyc_cnt;
    drive_for(1'b0, bitc);
    for (int i = 0; i < 8; i++) drive_for(b[i], bitc);
    drive_for(stop_ok, bitc);
    if (!stop_ok) drive_for(1'b1, 10);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_data"}, {24'h0, bus.rx_data}, 32'h0);
    check({tag, "_word_data"}, bus.word_data, 32'h0);
    check({tag, "_strobes"}, {29'h0, bus.rx_strobe, bus.frame_err, bus.word_valid}, 32'h0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Monitor: pops the scoreboard on every output event.
  initial forever begin
    @(negedge clk);
    if (bus.rx_strobe) begin
      strobes++;
      if (byte_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_byte: got 0x%02h, no byte expected", bus.rx_data);
      end else begin
        check("rx_byte", {24'h0, bus.rx_data}, {24'h0, byte_q.pop_front()});
      end
    end
    if (bus.frame_err) begin
      ferrs++;
      check("ferr_without_strobe", {31'h0, bus.rx_strobe}, 32'h0);
    end
    if (bus.word_valid) begin
      words++;
      word_cyc = cyc_cnt;
      check("word_after_term", {31'h0, prev_strobe && (prev_data == 8'h0D || prev_data == 8'h0A)}, 32'h1);
      if (word_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL word_data: got 0x%08h, no word expected", bus.word_data);
      end else begin
        check("word_data", bus.word_data, word_q.pop_front());
      end
    end
    prev_strobe = bus.rx_strobe;
    prev_data   = bus.rx_data;
  end

  initial begin
    vecs[0]  = '{"DEADBEEF\015",   1'b0, 50, 1, 32'hDEADBEEF, 9, 0};
    vecs[1]  = '{"1a\015\n",       1'b0, 50, 1, 32'h0000001A, 4, 0};
    vecs[2]  = '{"12G4\015",       1'b0, 50, 0, 32'h0000001A, 5, 0};
    vecs[3]  = '{"5\n",            1'b0, 50, 1, 32'h00000005, 2, 0};
    vecs[4]  = '{"123456789\015",  1'b0, 50, 0, 32'h00000005, 10, 0};
    vecs[5]  = '{"A7\015",         1'b1, 50, 0, 32'h00000005, 2, 1};
    vecs[6]  = '{"7\015",          1'b0, 50, 1, 32'h00000007, 2, 0};
    vecs[7]  = '{"\015",           1'b0, 50, 0, 32'h00000007, 1, 0};
    vecs[8]  = '{"abcdef09\n",     1'b0, 50, 1, 32'hABCDEF09, 9, 0};
    vecs[9]  = '{"C3\015",         1'b0, 52, 1, 32'h000000C3, 3, 0};
    vecs[10] = '{"5e\n",           1'b0, 48, 1, 32'h0000005E, 3, 0};

    reset = 1'b1;
    bus.uart_rx = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");
    drive_for(1'b1, 5);

    for (int v = 0; v < NVEC; v++) begin
      strobes  = 0;
      ferrs    = 0;
      words    = 0;
      word_cyc = -1;
      if (vecs[v].exp_words != 0) word_q.push_back(vecs[v].exp_word);
      for (int i = 0; i < vecs[v].text.len(); i++) begin
        bit ok;
        ok = !(vecs[v].bad_first && i == 0);
        if (ok) byte_q.push_back(vecs[v].text[i]);
        send_byte(vecs[v].text[i], ok, vecs[v].bitc);
      end
      drive_for(1'b1, 20);
      check($sformatf("v%0d_strobes", v), 32'(strobes), 32'(vecs[v].exp_strobes));
      check($sformatf("v%0d_ferrs", v), 32'(ferrs), 32'(vecs[v].exp_ferrs));
      check($sformatf("v%0d_words", v), 32'(words), 32'(vecs[v].exp_words));
      check($sformatf("v%0d_held_word", v), bus.word_data, vecs[v].exp_word);
      check($sformatf("v%0d_pending", v), 32'(byte_q.size() + word_q.size()), 32'h0);
      // Terminator pin fall to word_valid: 2 sync + 25 + 9*50 + 2 = 479 cycles.
      if (v == 0) check("latency", 32'(word_cyc - last_fall_cyc), 32'd479);
      byte_q.delete();
      word_q.delete();
    end

    strobes = 0;
    ferrs   = 0;
    drive_for(1'b0, 10);
    drive_for(1'b1, 600);
    check("glitch_strobes", 32'(strobes), 32'h0);
    check("glitch_ferrs", 32'(ferrs), 32'h0);

    // "FF\r" with reset during data bit 3 of the second 'F'; the line is then left idle.
    strobes = 0;
    words   = 0;
    byte_q.push_back(8'h46);
    send_byte(8'h46, 1'b1, 50);
    drive_for(1'b0, 50);
    drive_for(1'b0, 50);
    drive_for(1'b1, 50);
    drive_for(1'b1, 50);
    drive_for(1'b0, 25);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midbyte_reset");
    drive_for(1'b0, 24);
    drive_for(1'b1, 600);
    check("midbyte_strobes", 32'(strobes), 32'h1);
    check("midbyte_words", 32'(words), 32'h0);
    check("midbyte_word_data", bus.word_data, 32'h0);

    words = 0;
    word_q.push_back(32'h000000AB);
    byte_q.push_back(8'h41);
    send_byte(8'h41, 1'b1, 50);
    byte_q.push_back(8'h42);
    send_byte(8'h42, 1'b1, 50);
    byte_q.push_back(8'h0D);
    send_byte(8'h0D, 1'b1, 50);
    drive_for(1'b1, 20);
    check("after_reset_words", 32'(words), 32'h1);
    check("after_reset_word", bus.word_data, 32'h000000AB);
    check("after_reset_pending", 32'(byte_q.size() + word_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
